// File: rtl/sha256_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha256_sched_ctrl
// Purpose  : SHA-256 block sequencer. Buffers 16 message words, expands the
//            W[0..63] schedule and strobes the round datapath.
// Option   : SHA256_SCHED_OVERLAP_EN - rounds 0..15 issue as words arrive.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_sched_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int IDX_W      = 6
) (
    input  logic             C,
    input  logic             R,
    input  logic [31:0]      WORD_IN,
    input  logic             WORD_VALID,
    output logic             WORD_READY,
    input  logic             LAST_BLOCK,
    input  logic             HOLD,
    output logic             ROUND_EN,
    output logic [IDX_W-1:0] ROUND_IDX,
    output logic [31:0]      ROUND_W,
    output logic             HASH_INIT,
    output logic             BLOCK_DONE,
    output logic             MSG_DONE,
    output logic             BUSY
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_ROUNDS = 2'd2;
    localparam logic [1:0] c_FINAL  = 2'd3;

    localparam logic [4:0]       c_CNT_LAST = 5'd15;
    localparam logic [IDX_W-1:0] c_LAST_T   = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] c_T_ONE    = IDX_W'(1);
`ifdef SHA256_SCHED_OVERLAP_EN
    localparam logic [IDX_W-1:0] c_FIRST_T  = IDX_W'(16);
`else
    localparam logic [IDX_W-1:0] c_FIRST_T  = '0;
`endif

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [4:0]       r_cnt;
    logic [IDX_W-1:0] r_t;
    logic [31:0]      r_win [16];
    logic             r_new_msg;
    logic             r_last;
    logic             w_load_st;
    logic             w_ready;
    logic             w_xfer;
    logic             w_issue;
    logic [31:0]      w_w_next;
    logic [31:0]      w_round_w;

    assign w_load_st = (r_state == c_IDLE) || (r_state == c_LOAD);
    assign w_issue   = (r_state == c_ROUNDS) && !HOLD;
    assign w_xfer    = WORD_VALID && w_ready;

`ifdef SHA256_SCHED_OVERLAP_EN
    logic [31:0] r_wt;
    assign w_ready   = w_load_st && !HOLD;
    // Window holds W[t-16..t-1] and r_wt holds W[t]; W[t+1] uses the pre-shift window.
    assign w_w_next  = f_sig1(r_win[15]) + r_win[10] + f_sig0(r_win[2]) + r_win[1];
    assign w_round_w = r_wt;
`else
    assign w_ready   = w_load_st;
    // Window holds W[t..t+15]; the head is issued and W[t+16] refills the tail.
    assign w_w_next  = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];
    assign w_round_w = r_win[0];
`endif

    assign WORD_READY = w_ready;
    assign BUSY       = (r_state != c_IDLE);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_t       <= '0;
            r_new_msg <= 1'b1;
            r_last    <= 1'b0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
`ifdef SHA256_SCHED_OVERLAP_EN
            r_wt      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
                r_win[15] <= WORD_IN;
                r_new_msg <= 1'b0;
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt  <= '0;
                    r_last <= LAST_BLOCK;
                    r_t    <= c_FIRST_T;
`ifdef SHA256_SCHED_OVERLAP_EN
                    r_wt   <= w_w_next;
`endif
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end else if (w_issue) begin
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
`ifdef SHA256_SCHED_OVERLAP_EN
                r_win[15] <= r_wt;
                r_wt      <= w_w_next;
`else
                r_win[15] <= w_w_next;
`endif
                r_t <= (r_t == c_LAST_T) ? '0 : r_t + c_T_ONE;
            end
            // Next accepted word starts a fresh message once the final block closes.
            if ((r_state == c_FINAL) && r_last) r_new_msg <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ROUND_EN    = 1'b0;
        ROUND_IDX   = '0;
        ROUND_W     = '0;
        HASH_INIT   = 1'b0;
        BLOCK_DONE  = 1'b0;
        MSG_DONE    = 1'b0;
        case (r_state)
            c_IDLE, c_LOAD: begin
                // r_new_msg can only be set while idle, so this fires on word 0 only.
                HASH_INIT = w_xfer && r_new_msg;
`ifdef SHA256_SCHED_OVERLAP_EN
                ROUND_EN  = w_xfer;
                ROUND_W   = WORD_IN;
                ROUND_IDX = IDX_W'(r_cnt);
`endif
                if (w_xfer) begin
                    w_state_nxt = (r_cnt == c_CNT_LAST) ? c_ROUNDS : c_LOAD;
                end
            end
            c_ROUNDS: begin
                ROUND_EN  = !HOLD;
                ROUND_IDX = r_t;
                ROUND_W   = w_round_w;
                if (w_issue && (r_t == c_LAST_T)) w_state_nxt = c_FINAL;
            end
            c_FINAL: begin
                BLOCK_DONE  = 1'b1;
                MSG_DONE    = r_last;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_sched_ctrl.sv
`default_nettype none
// Directed bench for sha256_sched_ctrl with an independent W[] schedule model.
module tb_sha256_sched_ctrl;

    localparam int NUM_ROUNDS = 64;
    localparam int IDX_W      = 6;

    logic             C = 1'b0;
    logic             R;
    logic [31:0]      WORD_IN;
    logic             WORD_VALID;
    logic             WORD_READY;
    logic             LAST_BLOCK;
    logic             HOLD;
    logic             ROUND_EN;
    logic [IDX_W-1:0] ROUND_IDX;
    logic [31:0]      ROUND_W;
    logic             HASH_INIT;
    logic             BLOCK_DONE;
    logic             MSG_DONE;
    logic             BUSY;

    sha256_sched_ctrl #(.NUM_ROUNDS(NUM_ROUNDS), .IDX_W(IDX_W)) dut (
        .C(C), .R(R), .WORD_IN(WORD_IN), .WORD_VALID(WORD_VALID),
        .WORD_READY(WORD_READY), .LAST_BLOCK(LAST_BLOCK), .HOLD(HOLD),
        .ROUND_EN(ROUND_EN), .ROUND_IDX(ROUND_IDX), .ROUND_W(ROUND_W),
        .HASH_INIT(HASH_INIT), .BLOCK_DONE(BLOCK_DONE), .MSG_DONE(MSG_DONE),
        .BUSY(BUSY)
    );

    initial forever #5 C = ~C;

    int checks   = 0;
    int failures = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];

    int n_rounds, n_init, n_bd, n_md, n_hold, first_cyc, done_cyc;
    bit init_w0, idx_bad, hold_bad, msg_at_done, extra, timed_out;

    function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void build_expected();
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[t];
            end else begin
                s0 = ref_rotr(exp_w[t-15], 7) ^ ref_rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = ref_rotr(exp_w[t-2], 17) ^ ref_rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endfunction

    function automatic void fill_pattern(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) blk[i] = seed + (32'(i) * 32'h9E37_79B9);
    endfunction

    // Drives one block and records what the DUT does, one sample per cycle.
    task automatic drive_block(input bit last, input int gap, input bit hold_in_load,
                               input int hold_t, input int hold_len, input int abort_at);
        int cyc, widx, gapcnt, hold_left;
        bit v, stop, hr;
        n_rounds = 0; n_init = 0; n_bd = 0; n_md = 0; n_hold = 0;
        first_cyc = -1; done_cyc = -1;
        init_w0 = 0; idx_bad = 0; hold_bad = 0; msg_at_done = 0; extra = 0;
        for (int i = 0; i < 64; i++) obs_w[i] = 32'hDEAD_DEAD;
        cyc = 0; widx = 0; gapcnt = 0; hold_left = hold_len; stop = 0;
        while (!stop && cyc < 600) begin
            @(negedge C);
            v  = (widx < 16) && (gapcnt == 0);
            hr = (hold_t >= 0) && (hold_left > 0) && (n_rounds == hold_t) && (widx == 16);
            WORD_VALID = v;
            WORD_IN    = v ? blk[widx] : $urandom;
            LAST_BLOCK = (v && widx == 15) ? last : ~last;
            HOLD       = ((widx < 16) && hold_in_load) || hr;
            #1;
            if (HASH_INIT) n_init++;
            if (hr) begin
                n_hold++;
                hold_left--;
                if (ROUND_EN !== 1'b0 || int'(ROUND_IDX) != hold_t) hold_bad = 1;
            end
            if (v && WORD_READY) begin
                if (widx == 0) begin
                    first_cyc = cyc;
                    init_w0   = HASH_INIT;
                end
                widx++;
                gapcnt = gap;
            end else if (!v && gapcnt > 0) begin
                gapcnt--;
            end
            if (ROUND_EN) begin
                if (int'(ROUND_IDX) != n_rounds) idx_bad = 1;
                if (n_rounds < 64) obs_w[n_rounds] = ROUND_W;
                else extra = 1;
                n_rounds++;
            end
            if (MSG_DONE && !BLOCK_DONE) n_md++;
            if (BLOCK_DONE) begin
                n_bd++;
                done_cyc    = cyc;
                msg_at_done = MSG_DONE;
                stop = 1;
            end
            if (abort_at >= 0 && n_rounds > abort_at) stop = 1;
            cyc++;
        end
        WORD_VALID = 1'b0;
        HOLD       = 1'b0;
        timed_out  = !stop;
    endtask

    task automatic test_reset();
        R = 1'b1; WORD_VALID = 1'b0; WORD_IN = '0; LAST_BLOCK = 1'b0; HOLD = 1'b0;
        repeat (3) @(negedge C);
        #1;
        checks++; if (WORD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", WORD_READY); end
        checks++; if (ROUND_EN !== 1'b0) begin failures++; $display("FAIL reset_round_en: got %b expected 0", ROUND_EN); end
        checks++; if (ROUND_IDX !== '0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", ROUND_IDX); end
        checks++; if (ROUND_W !== '0) begin failures++; $display("FAIL reset_w: got %h expected 0", ROUND_W); end
        checks++; if (HASH_INIT !== 1'b0) begin failures++; $display("FAIL reset_init: got %b expected 0", HASH_INIT); end
        checks++; if (BLOCK_DONE !== 1'b0) begin failures++; $display("FAIL reset_bdone: got %b expected 0", BLOCK_DONE); end
        checks++; if (MSG_DONE !== 1'b0) begin failures++; $display("FAIL reset_mdone: got %b expected 0", MSG_DONE); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        @(negedge C);
        R = 1'b0;
    endtask

    task automatic test_abc();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        build_expected();
        drive_block(1'b1, 0, 1'b0, -1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL abc_timeout: got no BLOCK_DONE expected one within 600 cycles"); end
        checks++; if (init_w0 !== 1'b1) begin failures++; $display("FAIL abc_init_w0: got %b expected 1", init_w0); end
        checks++; if (n_init != 1) begin failures++; $display("FAIL abc_init_count: got %0d expected 1", n_init); end
        checks++; if (obs_w[16] !== 32'h6162_6380) begin failures++; $display("FAIL abc_w16: got %h expected 61626380", obs_w[16]); end
        checks++; if (obs_w[17] !== 32'h000F_0000) begin failures++; $display("FAIL abc_w17: got %h expected 000f0000", obs_w[17]); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL abc_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
        checks++; if (n_rounds != 64 || extra) begin failures++; $display("FAIL abc_rounds: got %0d expected 64", n_rounds); end
        checks++; if (idx_bad) begin failures++; $display("FAIL abc_idx_seq: got out-of-order ROUND_IDX expected 0..63"); end
        checks++; if (done_cyc - first_cyc != 80) begin failures++; $display("FAIL abc_latency: got %0d expected 80", done_cyc - first_cyc); end
        checks++; if (msg_at_done !== 1'b1 || n_md != 0) begin failures++; $display("FAIL abc_msg_done: got %b/%0d stray expected 1/0", msg_at_done, n_md); end
        @(negedge C); #1;
        checks++; if (BUSY !== 1'b0 || BLOCK_DONE !== 1'b0) begin failures++; $display("FAIL abc_after: got busy=%b bdone=%b expected 0/0", BUSY, BLOCK_DONE); end
    endtask

    task automatic test_two_block();
        fill_pattern(32'h0102_0304);
        build_expected();
        drive_block(1'b0, 0, 1'b0, -1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL two_a_timeout: got no BLOCK_DONE expected one"); end
        checks++; if (init_w0 !== 1'b1 || n_init != 1) begin failures++; $display("FAIL two_a_init: got %b/%0d expected 1/1", init_w0, n_init); end
        checks++; if (n_bd != 1 || msg_at_done !== 1'b0) begin failures++; $display("FAIL two_a_done: got bd=%0d md=%b expected 1/0", n_bd, msg_at_done); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL two_a_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
        fill_pattern(32'hA5A5_0F0F);
        build_expected();
        drive_block(1'b1, 0, 1'b0, -1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL two_b_timeout: got no BLOCK_DONE expected one"); end
        checks++; if (n_init != 0) begin failures++; $display("FAIL two_b_init: got %0d expected 0", n_init); end
        checks++; if (n_bd != 1 || msg_at_done !== 1'b1) begin failures++; $display("FAIL two_b_done: got bd=%0d md=%b expected 1/1", n_bd, msg_at_done); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL two_b_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
    endtask

    task automatic test_hold();
        fill_pattern(32'h5555_AAAA);
        build_expected();
        drive_block(1'b1, 0, 1'b0, 20, 5, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL hold_timeout: got no BLOCK_DONE expected one"); end
        checks++; if (n_hold != 5) begin failures++; $display("FAIL hold_cycles: got %0d expected 5", n_hold); end
        checks++; if (hold_bad) begin failures++; $display("FAIL hold_frozen: got round activity expected idx 20 and ROUND_EN 0"); end
        checks++; if (idx_bad || n_rounds != 64) begin failures++; $display("FAIL hold_seq: got %0d rounds bad=%b expected 64/0", n_rounds, idx_bad); end
        checks++; if (done_cyc - first_cyc != 85) begin failures++; $display("FAIL hold_latency: got %0d expected 85", done_cyc - first_cyc); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL hold_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
    endtask

    task automatic test_valid_gaps();
        fill_pattern(32'h3141_5926);
        build_expected();
        drive_block(1'b1, 2, 1'b1, -1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL gaps_timeout: got no BLOCK_DONE expected one"); end
        for (int t = 0; t < 16; t++) begin
            checks++;
            if (obs_w[t] !== blk[t]) begin failures++; $display("FAIL gaps_word t=%0d: got %h expected %h", t, obs_w[t], blk[t]); end
        end
        for (int t = 16; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL gaps_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
        checks++; if (n_rounds != 64 || idx_bad) begin failures++; $display("FAIL gaps_rounds: got %0d bad=%b expected 64/0", n_rounds, idx_bad); end
        checks++; if (done_cyc - first_cyc != 110) begin failures++; $display("FAIL gaps_latency: got %0d expected 110", done_cyc - first_cyc); end
    endtask

    task automatic test_reset_mid_block();
        fill_pattern(32'h1234_5678);
        drive_block(1'b0, 0, 1'b0, -1, 0, -1);
        checks++; if (timed_out || msg_at_done !== 1'b0) begin failures++; $display("FAIL mid_pre: got timeout=%b md=%b expected 0/0", timed_out, msg_at_done); end
        fill_pattern(32'hCAFE_F00D);
        drive_block(1'b1, 0, 1'b0, -1, 0, 30);
        checks++; if (timed_out || n_rounds != 31) begin failures++; $display("FAIL mid_reach30: got %0d rounds expected 31", n_rounds); end
        checks++; if (n_init != 0) begin failures++; $display("FAIL mid_cont_init: got %0d expected 0", n_init); end
        #2 R = 1'b1;
        #1;
        checks++; if (ROUND_EN !== 1'b0 || ROUND_IDX !== '0) begin failures++; $display("FAIL mid_async_round: got en=%b idx=%0d expected 0/0", ROUND_EN, ROUND_IDX); end
        checks++; if (ROUND_W !== '0) begin failures++; $display("FAIL mid_async_w: got %h expected 0", ROUND_W); end
        checks++; if (BUSY !== 1'b0 || WORD_READY !== 1'b1) begin failures++; $display("FAIL mid_async_state: got busy=%b ready=%b expected 0/1", BUSY, WORD_READY); end
        R = 1'b0;
        fill_pattern(32'h0BAD_BEEF);
        build_expected();
        drive_block(1'b1, 0, 1'b0, -1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL mid_post_timeout: got no BLOCK_DONE expected one"); end
        checks++; if (init_w0 !== 1'b1 || n_init != 1) begin failures++; $display("FAIL mid_post_init: got %b/%0d expected 1/1", init_w0, n_init); end
        checks++; if (done_cyc - first_cyc != 80 || msg_at_done !== 1'b1) begin failures++; $display("FAIL mid_post_done: got lat=%0d md=%b expected 80/1", done_cyc - first_cyc, msg_at_done); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_w[t] !== exp_w[t]) begin failures++; $display("FAIL mid_post_sched t=%0d: got %h expected %h", t, obs_w[t], exp_w[t]); end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_hold();
        test_valid_gaps();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
